// File: rtl/transmisor_teclado_ps2.sv
// Host-to-device PS/2 transmitter: request-to-send, then 8 data bits, odd parity and stop,
// then ACK sampling. Optional watchdog when TX_TIMEOUT_EN is defined.
module transmisor_teclado_ps2 #(
    parameter int unsigned RTS_CYCLES = 13000,
    parameter int unsigned FILTER_LEN = 8
`ifdef TX_TIMEOUT_EN
    ,
    parameter int unsigned TIMEOUT_CYCLES = 2000000
`endif
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       wr_ps2,
    input  logic [7:0] din,
    inout  tri         ps2clk,
    inout  tri         ps2data,
    output logic       tx_idle,
    output logic       tx_done_tick,
    output logic       ack_err
);

    localparam int unsigned CntW = $clog2(RTS_CYCLES + 1);
    localparam logic [CntW-1:0] RtsLast = CntW'(RTS_CYCLES - 1);

    typedef enum logic [2:0] {StIdle, StRts, StStart, StData, StStop, StAck} state_t;

    state_t                state;
    logic                  clk_low;
    logic                  data_low;
    logic [CntW-1:0]       cnt;
    logic [3:0]            n;
    logic [8:0]            shreg;

    logic                  clk_s1, clk_s2;
    logic                  data_s1, data_s2;
    logic [FILTER_LEN-1:0] filt;
    logic                  filt_val;
    logic                  fall_edge;

    // Lines are only ever pulled low; driver regs clear asynchronously on reset.
    assign ps2clk  = clk_low  ? 1'b0 : 1'bz;
    assign ps2data = data_low ? 1'b0 : 1'bz;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            clk_s1   <= 1'b1;
            clk_s2   <= 1'b1;
            data_s1  <= 1'b1;
            data_s2  <= 1'b1;
            filt     <= '1;
            filt_val <= 1'b1;
        end else begin
            clk_s1  <= ps2clk;
            clk_s2  <= clk_s1;
            data_s1 <= ps2data;
            data_s2 <= data_s1;
            filt    <= {filt[FILTER_LEN-2:0], clk_s2};
            if (&filt) begin
                filt_val <= 1'b1;
            end else if (~|filt) begin
                filt_val <= 1'b0;
            end
        end
    end

    assign fall_edge = filt_val & ~|filt;

`ifdef TX_TIMEOUT_EN
    localparam int unsigned WdW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WdW-1:0] WdLast = WdW'(TIMEOUT_CYCLES - 1);
    logic [WdW-1:0] wd;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= StIdle;
            clk_low      <= 1'b0;
            data_low     <= 1'b0;
            tx_idle      <= 1'b1;
            tx_done_tick <= 1'b0;
            ack_err      <= 1'b0;
            cnt          <= '0;
            n            <= '0;
            shreg        <= '0;
`ifdef TX_TIMEOUT_EN
            wd           <= '0;
`endif
        end else begin
            tx_done_tick <= 1'b0;
            unique case (state)
                StIdle: begin
                    // tx_idle stays low through the done-tick cycle, so a strobe there is ignored.
                    if (tx_idle && wr_ps2) begin
                        shreg   <= {~^din, din};
                        ack_err <= 1'b0;
                        cnt     <= '0;
                        clk_low <= 1'b1;
                        tx_idle <= 1'b0;
                        state   <= StRts;
                    end else begin
                        tx_idle <= 1'b1;
                    end
                end
                StRts: begin
                    if (cnt == RtsLast) begin
                        clk_low  <= 1'b0;
                        data_low <= 1'b1;
                        state    <= StStart;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                StStart: begin
                    if (fall_edge) begin
                        data_low <= ~shreg[0];
                        shreg    <= shreg >> 1;
                        n        <= 4'd8;
                        state    <= StData;
                    end
                end
                StData: begin
                    if (fall_edge) begin
                        data_low <= ~shreg[0];
                        shreg    <= shreg >> 1;
                        n        <= n - 1'b1;
                        if (n == 4'd1) begin
                            state <= StStop;
                        end
                    end
                end
                StStop: begin
                    if (fall_edge) begin
                        data_low <= 1'b0;
                        state    <= StAck;
                    end
                end
                StAck: begin
                    if (fall_edge) begin
                        ack_err      <= data_s2;
                        tx_done_tick <= 1'b1;
                        state        <= StIdle;
                    end
                end
                default: state <= StIdle;
            endcase
`ifdef TX_TIMEOUT_EN
            // Cleared through idle and rts so the count starts at zero on entry to start.
            if (state == StIdle || state == StRts || fall_edge) begin
                wd <= '0;
            end else if (wd == WdLast) begin
                wd           <= '0;
                clk_low      <= 1'b0;
                data_low     <= 1'b0;
                ack_err      <= 1'b1;
                tx_done_tick <= 1'b1;
                state        <= StIdle;
            end else begin
                wd <= wd + 1'b1;
            end
`endif
        end
    end

endmodule

// File: tb/tb_transmisor_teclado_ps2.sv
// Bench for transmisor_teclado_ps2: PS/2 device model plus done-tick scoreboard.
module tb_transmisor_teclado_ps2;

    localparam int RTS  = 40;
    localparam int HALF = 20;
`ifdef TX_TIMEOUT_EN
    localparam int TMO       = 600;
    localparam int EXP_DONES = 7;
`else
    localparam int TMO       = 600;
    localparam int EXP_DONES = 6;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       wr_ps2 = 1'b0;
    logic [7:0] din = 8'h00;
    wire        ps2clk;
    wire        ps2data;
    logic       tx_idle, tx_done_tick, ack_err;

    logic dev_clk_low = 1'b0;
    logic dev_data_low = 1'b0;
    assign ps2clk  = dev_clk_low  ? 1'b0 : 1'bz;
    assign ps2data = dev_data_low ? 1'b0 : 1'bz;
    pullup (ps2clk);
    pullup (ps2data);

    transmisor_teclado_ps2 #(
        .RTS_CYCLES(RTS),
        .FILTER_LEN(8)
`ifdef TX_TIMEOUT_EN
        ,
        .TIMEOUT_CYCLES(TMO)
`endif
    ) dut (
        .clk(clk),
        .reset(reset),
        .wr_ps2(wr_ps2),
        .din(din),
        .ps2clk(ps2clk),
        .ps2data(ps2data),
        .tx_idle(tx_idle),
        .tx_done_tick(tx_done_tick),
        .ack_err(ack_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] b;
        logic       par;
        logic       ack;
        bit         chkb;
    } exp_t;

    exp_t       q[$];
    int         total = 0;
    int         bad = 0;
    int         dones = 0;
    logic [7:0] dev_byte;
    logic       dev_par, dev_stop, dev_start;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Scoreboard monitor
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (tx_done_tick) begin
                dones++;
                if (q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_done: got tick expected none (t=%0t)", $time);
                end else begin
                    e = q.pop_front();
                    chk("ack_err", ack_err, e.ack);
                    if (e.chkb) begin
                        chk("rx_byte", dev_byte, e.b);
                        chk("rx_parity", dev_par, e.par);
                        chk("rx_stop", dev_stop, 1);
                        chk("rx_start", dev_start, 0);
                    end
                end
            end
        end
    end

    task automatic send(input logic [7:0] b, input logic par, input logic ack,
                        input bit push, input bit chkb);
        @(negedge clk);
        din    = b;
        wr_ps2 = 1'b1;
        if (push) q.push_back('{b, par, ack, chkb});
        @(posedge clk);
        #1;
        wr_ps2 = 1'b0;
        chk("rts_latency", ps2clk, 0);
        chk("busy_after_wr", tx_idle, 0);
        chk("ack_err_cleared", ack_err, 0);
    endtask

    // Device: measures RTS, then clocks n_edges falling edges.
    task automatic dev_frame(input logic ack, input int n_edges, input bit glitch);
        int cyc = 0;
        while (ps2clk == 1'b0 && cyc < 5000) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        chk("rts_len", cyc, RTS);
        repeat (30) @(negedge clk);
        dev_start = ps2data;
        for (int i = 0; i < n_edges; i++) begin
            if (i == 10) dev_data_low = ~ack;
            dev_clk_low = 1'b1;
            repeat (HALF) @(negedge clk);
            if (i < 8) dev_byte[i] = ps2data;
            else if (i == 8) dev_par = ps2data;
            else if (i == 9) dev_stop = ps2data;
            dev_clk_low = 1'b0;
            if (glitch && i >= 1 && i < 8) begin
                repeat (8) @(negedge clk);
                dev_clk_low = 1'b1;
                repeat (3) @(negedge clk);
                dev_clk_low = 1'b0;
                repeat (9) @(negedge clk);
            end else begin
                repeat (HALF) @(negedge clk);
            end
            if (i == 10) dev_data_low = 1'b0;
        end
    endtask

    task automatic wait_idle();
        int cyc = 0;
        while (tx_idle !== 1'b1 && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        chk("idle_return", tx_idle, 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got hang expected finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_idle", tx_idle, 1);
        chk("rst_done", tx_done_tick, 0);
        chk("rst_ack_err", ack_err, 0);
        chk("rst_clk_z", ps2clk, 1);
        chk("rst_data_z", ps2data, 1);
        reset = 1'b1;
        repeat (5) @(negedge clk);

        // 0xED, ACK=0; parity 1
        send(8'hED, 1'b1, 1'b0, 1, 1);
        dev_frame(1'b0, 11, 0);
        wait_idle();

        // 0xFF with NACK; parity 1
        send(8'hFF, 1'b1, 1'b1, 1, 1);
        dev_frame(1'b1, 11, 0);
        wait_idle();
        chk("nack_held", ack_err, 1);

        // 0x01 parity 0 (clears ack_err), 0x00 parity 1
        send(8'h01, 1'b0, 1'b0, 1, 1);
        dev_frame(1'b0, 11, 0);
        wait_idle();
        send(8'h00, 1'b1, 1'b0, 1, 1);
        dev_frame(1'b0, 11, 0);
        wait_idle();

        // 0xF4 (parity 0) with an ignored 0xAA strobe mid-frame
        send(8'hF4, 1'b0, 1'b0, 1, 1);
        fork
            dev_frame(1'b0, 11, 0);
            begin
                repeat (150) @(negedge clk);
                din    = 8'hAA;
                wr_ps2 = 1'b1;
                @(negedge clk);
                wr_ps2 = 1'b0;
            end
        join
        wait_idle();

        // 0x3C (parity 1) with short clock glitches during data
        send(8'h3C, 1'b1, 1'b0, 1, 1);
        dev_frame(1'b0, 11, 1);
        wait_idle();

        // Reset in mid-data with a 0 bit being driven
        send(8'h00, 1'b1, 1'b0, 0, 0);
        dev_frame(1'b0, 4, 0);
        chk("mid_data_low", ps2data, 0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("async_clk_z", ps2clk, 1);
        chk("async_data_z", ps2data, 1);
        chk("async_idle", tx_idle, 1);
        chk("async_ack_err", ack_err, 0);
        chk("async_no_done", tx_done_tick, 0);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        repeat (5) @(negedge clk);

        // Silent device after RTS
`ifdef TX_TIMEOUT_EN
        send(8'h55, 1'b1, 1'b1, 1, 0);
        repeat (RTS + TMO + 20) @(negedge clk);
        chk("tmo_idle", tx_idle, 1);
        chk("tmo_clk_z", ps2clk, 1);
        chk("tmo_data_z", ps2data, 1);
        chk("tmo_ack_err", ack_err, 1);
`else
        send(8'h55, 1'b1, 1'b0, 0, 0);
        repeat (RTS + TMO + 20) @(negedge clk);
        chk("silent_busy", tx_idle, 0);
        chk("silent_start_low", ps2data, 0);
        chk("silent_clk_z", ps2clk, 1);
        @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
`endif

        repeat (20) @(negedge clk);
        chk("queue_empty", q.size(), 0);
        chk("done_count", dones, EXP_DONES);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
